ascon_fsm: RTL and testbench

- Control FSM for the ASCON-128 permutation datapath: the state mux, begin-XOR, round function and state register stage.
- Sequences initialisation (p^a), associated-data absorption (p^b), plaintext encryption (p^b) and finalisation (p^a).
- Drives the round index, mux select, register enable, XOR controls and the cipher/tag capture enables.
- Sits directly upstream of the permutation stage; the datapath has no autonomous control.

---
 rtl/ascon_fsm_if.sv | 27 ++
 rtl/ascon_fsm.sv | 73 +++++++
 tb/tb_ascon_fsm.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ascon_fsm_if.sv
// ascon_fsm_if: handshake and datapath-control bundle between the ASCON controller and its environment
interface ascon_fsm_if;
  logic       start_i;
  logic       data_valid_i;
  logic       data_ready_o;
  logic [3:0] round_o;
  logic       selectionp_o;
  logic       enable_o;
  logic       bypass_o;
  logic       mode_int_ext_o;
  logic       xor_key_end_o;
  logic       xor_lsb_end_o;
  logic       en_cipher_o;
  logic       en_tag_o;
  logic       busy_o;
  logic       done_o;
  modport master (
    output start_i, data_valid_i,
    input  data_ready_o, round_o, selectionp_o, enable_o, bypass_o, mode_int_ext_o,
           xor_key_end_o, xor_lsb_end_o, en_cipher_o, en_tag_o, busy_o, done_o
  );
  modport slave (
    input  start_i, data_valid_i,
    output data_ready_o, round_o, selectionp_o, enable_o, bypass_o, mode_int_ext_o,
           xor_key_end_o, xor_lsb_end_o, en_cipher_o, en_tag_o, busy_o, done_o
  );
endinterface

// File: rtl/ascon_fsm.sv
// ascon_fsm: control sequencer for the ASCON-128 permutation datapath (init, AD, PT, finalisation)
module ascon_fsm #(
  parameter int AD_BLOCKS = 1,
  parameter int PT_BLOCKS = 4
) (
  input logic        clock_i,
  input logic        resetb_i,
  ascon_fsm_if.slave bus
);
  localparam int MB = AD_BLOCKS > PT_BLOCKS ? AD_BLOCKS : PT_BLOCKS;
  localparam int BW = MB > 1 ? $clog2(MB) : 1;
  typedef enum logic [2:0] {IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE} state_t;
  state_t state;
  logic [3:0] rnd;
  logic [BW-1:0] blk;
  logic last_r, last_ad, last_pt, wv, run;
  assign last_r  = rnd == 4'd11;
  assign last_ad = blk == BW'(AD_BLOCKS - 1);
  assign last_pt = blk == BW'(PT_BLOCKS - 1);
  assign run     = state == INIT || state == AD || state == PT || state == FINAL;
  // A valid block in a WAIT state executes its first round in the same cycle
  assign wv      = (state == WAIT_AD || state == WAIT_PT) && bus.data_valid_i;
  always_ff @(posedge clock_i) begin
    if (resetb_i) begin
      state <= IDLE;
      rnd   <= '0;
      blk   <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start_i) begin
          state <= INIT;
          rnd   <= '0;
          blk   <= '0;
        end
        INIT: if (last_r) begin
          state <= WAIT_AD;
          blk   <= '0;
        end else rnd <= rnd + 4'd1;
        WAIT_AD: if (bus.data_valid_i) begin
          state <= AD;
          rnd   <= 4'd7;
        end
        AD: if (last_r) begin
          state <= last_ad ? WAIT_PT : WAIT_AD;
          blk   <= last_ad ? '0 : blk + BW'(1);
        end else rnd <= rnd + 4'd1;
        WAIT_PT: if (bus.data_valid_i) begin
          state <= last_pt ? FINAL : PT;
          rnd   <= last_pt ? 4'd1 : 4'd7;
        end
        PT: if (last_r) begin
          state <= WAIT_PT;
          blk   <= blk + BW'(1);
        end else rnd <= rnd + 4'd1;
        FINAL: if (last_r) state <= DONE;
        else rnd <= rnd + 4'd1;
      endcase
    end
  end
  assign bus.busy_o         = state != IDLE && state != DONE;
  assign bus.done_o         = state == DONE;
  assign bus.data_ready_o   = wv;
  assign bus.enable_o       = run || wv;
  assign bus.bypass_o       = !wv;
  // The last plaintext block starts finalisation: its first round is p^a round 0
  assign bus.round_o        = wv ? ((state == WAIT_PT && last_pt) ? 4'd0 : 4'd6) : rnd;
  assign bus.selectionp_o   = bus.busy_o && !(state == INIT && rnd == 4'd0);
  assign bus.mode_int_ext_o = wv && state == WAIT_PT && last_pt;
  assign bus.xor_key_end_o  = last_r && (state == INIT || state == FINAL);
  assign bus.xor_lsb_end_o  = state == AD && last_r && last_ad;
  assign bus.en_cipher_o    = wv && state == WAIT_PT;
  assign bus.en_tag_o       = state == FINAL && last_r;
endmodule

// File: tb/tb_ascon_fsm.sv
// tb_ascon_fsm: scoreboard bench for the ASCON control FSM; expected control events are queued from cycle formulas
module tb_ascon_fsm;
  localparam int AD = 1;
  localparam int PT = 4;
  logic clk = 1'b0;
  logic resetb = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    int         cyc;
    logic [6:0] f;
    logic [3:0] r;
  } ev_t;
  ev_t q[$];
  ascon_fsm_if bus();
  ascon_fsm #(.AD_BLOCKS(AD), .PT_BLOCKS(PT)) dut (.clock_i(clk), .resetb_i(resetb), .bus(bus));
  always #5 clk = ~clk;
  // Event flags: {data_ready, en_cipher, xor_lsb_end, xor_key_end, en_tag, mode, selectionp low while busy}
  function automatic logic [6:0] flags();
    return {bus.data_ready_o, bus.en_cipher_o, bus.xor_lsb_end_o, bus.xor_key_end_o,
            bus.en_tag_o, bus.mode_int_ext_o, bus.busy_o & ~bus.selectionp_o};
  endfunction
  task automatic push_ev(input int c, input logic [6:0] f, input logic [3:0] r, input int lim);
    ev_t e;
    e.cyc = c;
    e.f = f;
    e.r = r;
    if (c <= lim) q.push_back(e);
  endtask
  task automatic run_msg(input int k, input int s, input bit poke, input int abort_at);
    int p, fin, total, lim, c0;
    ev_t e;
    logic [6:0] f;
    p = 13 + 6 * AD;
    fin = 18 + 6 * AD + 6 * PT + s;
    lim = abort_at >= 0 ? abort_at : fin;
    total = abort_at >= 0 ? abort_at + 30 : fin + 1;
    q.delete();
    push_ev(1, 7'b0000001, 4'd0, lim);
    push_ev(12, 7'b0001000, 4'd11, lim);
    for (int a = 0; a < AD; a++) begin
      push_ev(13 + 6 * a, 7'b1000000, 4'd6, lim);
      if (a == AD - 1) push_ev(18 + 6 * a, 7'b0010000, 4'd11, lim);
    end
    for (int j = 0; j < PT; j++) begin
      c0 = p + 6 * j + (j >= k ? s : 0);
      if (j == PT - 1) push_ev(c0, 7'b1100010, 4'd0, lim);
      else push_ev(c0, 7'b1100000, 4'd6, lim);
    end
    push_ev(fin, 7'b0001100, 4'd11, lim);
    for (int c = 0; c <= total; c++) begin
      @(negedge clk);
      resetb = abort_at == c;
      bus.start_i = c == 0 || (poke && (c == 15 || c == 40));
      bus.data_valid_i = poke ? (c == 5 || c == 13 || c >= 19) : !(c >= p + 6 * k && c < p + 6 * k + s);
      #1;
      f = flags();
      if (f != 7'd0) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event cycle=%0d got flags=%b round=%0d, required no event", c, f, bus.round_o);
        end else begin
          e = q.pop_front();
          if (e.cyc !== c || e.f !== f || e.r !== bus.round_o) begin
            miscompares++;
            $display("FAIL event got cycle=%0d flags=%b round=%0d, required cycle=%0d flags=%b round=%0d",
                     c, f, bus.round_o, e.cyc, e.f, e.r);
          end
        end
      end
      if (s > 0 && c >= p + 6 * k && c < p + 6 * k + s) begin
        vectors++;
        if (bus.enable_o !== 1'b0 || bus.round_o !== 4'd11) begin
          miscompares++;
          $display("FAIL stall cycle=%0d got enable=%b round=%0d, required enable=0 round=11", c, bus.enable_o, bus.round_o);
        end
      end
      if (c == 1) begin
        vectors++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
          miscompares++;
          $display("FAIL init_entry got done=%b busy=%b, required done=0 busy=1", bus.done_o, bus.busy_o);
        end
      end
      if (abort_at >= 0 && c > abort_at) begin
        vectors++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.enable_o !== 1'b0 || bus.bypass_o !== 1'b1) begin
          miscompares++;
          $display("FAIL abort_idle cycle=%0d got busy=%b done=%b enable=%b bypass=%b, required 0 0 0 1",
                   c, bus.busy_o, bus.done_o, bus.enable_o, bus.bypass_o);
        end
      end
      if (abort_at < 0 && c >= total - 1) begin
        vectors++;
        if (bus.done_o !== (c == total) || bus.busy_o !== (c != total)) begin
          miscompares++;
          $display("FAIL done_timing cycle=%0d got done=%b busy=%b, required done=%b", c, bus.done_o, bus.busy_o, c == total);
        end
      end
    end
    bus.start_i = 1'b0;
    bus.data_valid_i = 1'b0;
    resetb = 1'b0;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_events got %0d pending, required 0 (next at cycle %0d)", q.size(), q[0].cyc);
    end
  endtask
  task automatic test_reset();
    bus.start_i = 1'b1;
    bus.data_valid_i = 1'b1;
    resetb = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      vectors++;
      if ({bus.data_ready_o, bus.round_o, bus.selectionp_o, bus.enable_o, bus.mode_int_ext_o, bus.xor_key_end_o,
           bus.xor_lsb_end_o, bus.en_cipher_o, bus.en_tag_o, bus.busy_o, bus.done_o} !== 14'd0 || bus.bypass_o !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_outputs got round=%0d enable=%b bypass=%b busy=%b done=%b, required all 0 and bypass=1",
                 bus.round_o, bus.enable_o, bus.bypass_o, bus.busy_o, bus.done_o);
      end
    end
    bus.start_i = 1'b0;
    bus.data_valid_i = 1'b0;
    resetb = 1'b0;
  endtask
  task automatic test_idle();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.data_valid_i = c[0];
      #1;
      vectors++;
      if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.enable_o !== 1'b0 || bus.data_ready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_hold cycle=%0d got busy=%b done=%b enable=%b ready=%b, required all 0",
                 c, bus.busy_o, bus.done_o, bus.enable_o, bus.data_ready_o);
      end
    end
    bus.data_valid_i = 1'b0;
  endtask
  task automatic test_full_message();
    run_msg(0, 0, 1'b0, -1);
  endtask
  task automatic test_valid_stall();
    run_msg(1, 5, 1'b0, -1);
  endtask
  task automatic test_ignored_inputs();
    run_msg(0, 0, 1'b1, -1);
  endtask
  task automatic test_reset_mid();
    run_msg(0, 0, 1'b0, 22);
    run_msg(0, 0, 1'b0, -1);
  endtask
  task automatic test_restart();
    #1;
    vectors++;
    if (bus.done_o !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_precondition got done=%b, required 1", bus.done_o);
    end
    run_msg(0, 0, 1'b0, -1);
  endtask
  initial begin
    bus.start_i = 1'b0;
    bus.data_valid_i = 1'b0;
    test_reset();
    test_idle();
    test_full_message();
    test_valid_stall();
    test_ignored_inputs();
    test_reset_mid();
    test_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
